// File: rtl/s_scale_acc_pipe.sv
// Two-stage scale/accumulate stage for CORDIC iteration pipelines:
// oData = sat(iAcc +/- round_or_floor(((iData >>> iShift) * iK) / 2^KWIDTH)).
module s_scale_acc_pipe #(
  parameter int DWIDTH = 16,
  parameter int KWIDTH = 4,
  parameter int SWIDTH = $clog2(DWIDTH)
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DWIDTH-1:0] iData,
  input  logic [SWIDTH-1:0] iShift,
  input  logic [KWIDTH-1:0] iK,
  input  logic [DWIDTH-1:0] iAcc,
  input  logic              iAccEn,
  input  logic              iSub,
  input  logic              iRound,
  output logic              oValid,
  input  logic              iReady,
  output logic [DWIDTH-1:0] oData,
  output logic              oSat
);

  localparam int PW = DWIDTH + KWIDTH;
  localparam logic signed [PW-1:0] RND_HALF = PW'(1) << (KWIDTH - 1);
  localparam logic [DWIDTH-1:0] DMAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] DMIN = {1'b1, {(DWIDTH-1){1'b0}}};

  // Handshake: a transfer happens on any edge where valid and ready are both
  // high; a stage loads when it is empty or the stage after it is moving.
  // oReady depends combinationally on iReady so a full pipe can still accept
  // a new input in the same cycle its oldest result leaves.
  logic en1, en2;
  logic v1, v2;

  assign en2    = !v2 || iReady;
  assign en1    = !v1 || en2;
  assign oReady = en1;
  assign oValid = v2;

  // Stage 1 datapath: arithmetic shift then full-precision signed product.
  logic signed [DWIDTH-1:0] sh_c;
  logic signed [PW-1:0]     prod_c;

  assign sh_c   = $signed(iData) >>> iShift;
  assign prod_c = PW'(sh_c) * PW'($signed(iK));

  logic signed [PW-1:0] prod1;
  logic [DWIDTH-1:0]    acc1;
  logic                 acc_en1, sub1, round1;

  // Stage 2 datapath. The biased product cannot overflow PW bits because the
  // largest product magnitude is 2^(PW-2), leaving room for the rounding bias.
  logic signed [PW-1:0]     biased_c;
  logic signed [DWIDTH-1:0] r_c;
  logic signed [DWIDTH:0]   sum_c;
  logic [DWIDTH-1:0]        data_c;
  logic                     sat_c;

  assign biased_c = round1 ? (prod1 + RND_HALF) : prod1;
  assign r_c      = DWIDTH'(biased_c >>> KWIDTH);
  assign sum_c    = sub1 ? ($signed({acc1[DWIDTH-1], acc1}) - $signed({r_c[DWIDTH-1], r_c}))
                         : ($signed({acc1[DWIDTH-1], acc1}) + $signed({r_c[DWIDTH-1], r_c}));

  always_comb begin
    data_c = r_c;
    sat_c  = 1'b0;
    if (acc_en1) begin
      // Overflow of the DWIDTH+1 sum shows up as disagreeing top two bits.
      if (sum_c[DWIDTH] != sum_c[DWIDTH-1]) begin
        sat_c  = 1'b1;
        data_c = sum_c[DWIDTH] ? DMIN : DMAX;
      end else begin
        data_c = sum_c[DWIDTH-1:0];
      end
    end
  end

  logic [DWIDTH-1:0] data2;
  logic              sat2;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      prod1   <= '0;
      acc1    <= '0;
      acc_en1 <= 1'b0;
      sub1    <= 1'b0;
      round1  <= 1'b0;
      data2   <= '0;
      sat2    <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= iValid;
        if (iValid) begin
          prod1   <= prod_c;
          acc1    <= iAcc;
          acc_en1 <= iAccEn;
          sub1    <= iSub;
          round1  <= iRound;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          data2 <= data_c;
          sat2  <= sat_c;
        end
      end
    end
  end

  assign oData = data2;
  assign oSat  = sat2;

endmodule

// File: tb/tb_s_scale_acc_pipe.sv
// Directed bench for s_scale_acc_pipe: vector table, latency, random stream,
// backpressure and mid-flight reset, all checked through one expected queue.
module tb_s_scale_acc_pipe;

  localparam int DW = 16;
  localparam int KW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid, ready_up, ready_dn, out_valid, out_sat;
  logic [DW-1:0] data, acc, out_data;
  logic [SW-1:0] shift;
  logic [KW-1:0] k;
  logic          acc_en, sub, rnd;

  always #5 clk = ~clk;

  s_scale_acc_pipe #(.DWIDTH(DW), .KWIDTH(KW), .SWIDTH(SW)) dut (
    .iClk(clk), .iRstN(rst_n), .iValid(valid), .oReady(ready_up),
    .iData(data), .iShift(shift), .iK(k), .iAcc(acc), .iAccEn(acc_en),
    .iSub(sub), .iRound(rnd), .oValid(out_valid), .iReady(ready_dn),
    .oData(out_data), .oSat(out_sat)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  shift;
    logic [3:0]  k;
    logic [15:0] acc;
    logic        acc_en;
    logic        sub;
    logic        rnd;
    logic [15:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t        vecs[17];
  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;
  int          cycle = 0;
  int          out_count = 0;
  int          first_out = -1;
  int          last_out = -1;

  always @(posedge clk) cycle++;

  // Scoreboard: an output transfer is due at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && ready_dn) begin
      out_count++;
      if (first_out < 0) first_out = cycle;
      last_out = cycle;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected data=%h sat=%b expected nothing", out_data, out_sat);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_sat, out_data} !== mon_exp) begin
          fails++;
          $display("FAIL out_data got data=%h sat=%b expected data=%h sat=%b",
                   out_data, out_sat, mon_exp[15:0], mon_exp[16]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] sh,
                                        input logic [3:0] kk, input logic [15:0] a,
                                        input logic en, input logic sb, input logic rd);
    longint sd, p, r, s;
    sd = longint'($signed(d)) >>> sh;
    p  = sd * longint'($signed(kk));
    if (rd) p = p + 8;
    r  = p >>> 4;
    if (!en) return {1'b0, r[15:0]};
    s = sb ? longint'($signed(a)) - r : longint'($signed(a)) + r;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  task automatic drive(input vec_t v);
    valid  = 1'b1;
    data   = v.data;
    shift  = v.shift;
    k      = v.k;
    acc    = v.acc;
    acc_en = v.acc_en;
    sub    = v.sub;
    rnd    = v.rnd;
  endtask

  task automatic wait_accept(input logic [16:0] e);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = ready_up;
      @(posedge clk);
      #1;
      n++;
    end
    if (seen) exp_q.push_back(e);
    else begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got=no_accept expected=accept");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   c0;
    valid = 1'b0; ready_dn = 1'b1; data = '0; shift = '0; k = '0;
    acc = '0; acc_en = 1'b0; sub = 1'b0; rnd = 1'b0;

    //             data     sh     k      acc      en    sub   rnd   exp      sat
    vecs[0]  = '{16'h0A00, 4'd9,  4'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[1]  = '{16'h0A00, 4'd9,  4'd5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0};
    vecs[2]  = '{16'hF600, 4'd9,  4'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFE, 1'b0};
    vecs[3]  = '{16'hF600, 4'd9,  4'd5, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    vecs[4]  = '{16'h8000, 4'd0,  4'h8, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0};
    vecs[5]  = '{16'h7FFF, 4'd0,  4'd7, 16'h7FF0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1};
    vecs[6]  = '{16'h7FFF, 4'd0,  4'd7, 16'h8000, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b1};
    vecs[7]  = '{16'h0A00, 4'd9,  4'd5, 16'h0100, 1'b1, 1'b1, 1'b0, 16'h00FF, 1'b0};
    vecs[8]  = '{16'h0123, 4'd0,  4'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0012, 1'b0};
    vecs[9]  = '{16'h8000, 4'd15, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vecs[10] = '{16'h7FFF, 4'd15, 4'd7, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{16'h8000, 4'd15, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[12] = '{16'h0A00, 4'd9,  4'd5, 16'h7FFE, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b0};
    vecs[13] = '{16'h0A00, 4'd9,  4'd5, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1};
    vecs[14] = '{16'h0A00, 4'd9,  4'd5, 16'h8001, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b0};
    vecs[15] = '{16'h4000, 4'd9,  4'hD, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFA, 1'b0};
    vecs[16] = '{16'hFFFE, 4'd0,  4'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_ready", ready_up, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency from presentation: stage 1 after one edge, output after two.
    @(posedge clk);
    #1;
    drive(vecs[0]);
    wait_accept({vecs[0].exp_sat, vecs[0].exp_data});
    valid = 1'b0;
    check("lat_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_two_cycles", out_valid, 1);
    check("lat_data", out_data, 16'h0001);
    drain();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i]);
      wait_accept({vecs[i].exp_sat, vecs[i].exp_data});
    end
    drain();

    // Back-to-back random stream with the downstream always ready.
    out_count = 0;
    first_out = -1;
    c0 = cycle;
    for (int i = 0; i < 8; i++) begin
      v.data   = 16'($urandom_range(0, 65535));
      v.shift  = 4'($urandom_range(0, 15));
      v.k      = 4'($urandom_range(0, 15));
      v.acc    = 16'($urandom_range(0, 65535));
      v.acc_en = 1'($urandom_range(0, 1));
      v.sub    = 1'($urandom_range(0, 1));
      v.rnd    = 1'($urandom_range(0, 1));
      drive(v);
      wait_accept(model(v.data, v.shift, v.k, v.acc, v.acc_en, v.sub, v.rnd));
    end
    check("stream_accept_rate", cycle - c0, 8);
    drain();
    check("stream_count", out_count, 8);
    check("stream_no_bubble", last_out - first_out, 7);

    // Backpressure: two accepts fill the pipe, then the head must hold.
    ready_dn = 1'b0;
    drive(vecs[5]);
    wait_accept({vecs[5].exp_sat, vecs[5].exp_data});
    drive(vecs[7]);
    wait_accept({vecs[7].exp_sat, vecs[7].exp_data});
    drive(vecs[9]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", ready_up, 0);
      check("bp_valid_hold", out_valid, 1);
      check("bp_data_hold", {out_sat, out_data}, {1'b1, 16'h7FFF});
      @(posedge clk);
      #1;
    end
    ready_dn = 1'b1;
    wait_accept({vecs[9].exp_sat, vecs[9].exp_data});
    drain();

    // Reset with a full pipe: everything in flight is discarded.
    ready_dn = 1'b0;
    drive(vecs[0]);
    wait_accept({vecs[0].exp_sat, vecs[0].exp_data});
    drive(vecs[1]);
    wait_accept({vecs[1].exp_sat, vecs[1].exp_data});
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_sat", out_sat, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ghost", out_valid, 0);
    end
    @(posedge clk);
    #1;
    drive(vecs[2]);
    wait_accept({vecs[2].exp_sat, vecs[2].exp_data});
    valid = 1'b0;
    check("postrst_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("postrst_valid", out_valid, 1);
    check("postrst_data", out_data, 16'hFFFE);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
